cnn_pixel_streamer: RTL and testbench
=====================================

# cnn_pixel_streamer

Double-buffered image loader directly upstream of `cnn_top`. It accepts 8-bit pixels from a byte source (UART/DMA front end) over a ready/valid handshake and stores them in one of two 784-entry frame buffers. Each complete 28×28 frame is replayed to `cnn_top` as one contiguous burst of 784 valid cycles. A fixed idle gap follows each burst so the CNN pipeline drains before the next frame starts.

## Interface
Parameters:
- `PIX_W`, 8: pixel width in bits.
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels. `NPIX = IMG_W*IMG_H` (784).
- `FRAME_GAP`, 500: minimum idle cycles between bursts. Must be ≥ 1.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `wr_data`  in  PIX_W: incoming pixel.
- `wr_valid`  in  1: `wr_data` is valid.
- `wr_ready`  out  1: a buffer is available. A pixel transfers on an edge where `wr_valid && wr_ready`.
- `pix_out`  out  PIX_W: pixel to `cnn_top` `d_in`.
- `pix_valid`  out  1: to `cnn_top` `in_valid`.
- `frame_start`  out  1: one-cycle pulse together with pixel 0.
- `frame_last`  out  1: one-cycle pulse together with pixel NPIX-1.
- `buf_full`  out  2: per-buffer full flags (status).

## Operation
- The two buffers are each NPIX×PIX_W, with one write port and one registered read port (1-cycle read latency).
- Writer side:
  - `wr_sel` selects the buffer being filled. `wr_addr` counts 0..NPIX-1.
  - `wr_ready = !buf_full[wr_sel]`. This is combinational from registers only.
  - When the transfer at `wr_addr = NPIX-1` happens: set `buf_full[wr_sel]`, toggle `wr_sel`, clear `wr_addr`.
  - Pixels presented while `wr_ready` is low are not accepted. The source must hold them.
- Reader FSM:
  - IDLE: if `buf_full[rd_sel]`, go to STREAM with `rd_addr = 0`.
  - STREAM: issue reads for `rd_addr` 0..NPIX-1, one per cycle, with no stalls. On the cycle the read of NPIX-1 is issued, clear `buf_full[rd_sel]`, toggle `rd_sel`, and go to GAP.
  - GAP: count FRAME_GAP cycles, then go to IDLE.
- `pix_valid`, `pix_out`, `frame_start` and `frame_last` are registered alongside the read data. They describe the address issued one cycle earlier.
- Pixel order is raster: row-major, in arrival order, no reordering.
- Simultaneous events:
  - The writer completing buffer A on the same edge the reader releases buffer B: both flag updates take effect.
  - The writer waiting on a full buffer that is released on edge E: `wr_ready` is high after E.
- A frame in progress at the writer is never visible to the reader until all NPIX pixels have been written.

## Timing
- Reset values (on an edge with `rst_n` low):
  - `wr_sel = rd_sel = 0`, `wr_addr = rd_addr = 0`, `buf_full = 2'b00`.
  - FSM in IDLE, gap counter 0.
  - `pix_valid = frame_start = frame_last = 0`, `pix_out = 0`.
  - `wr_ready = 1` after reset.
- Reset mid-operation aborts everything. The partial frame is discarded, and `pix_valid` is low from the first post-reset cycle onward.
- Latency: the last pixel of a frame is accepted on edge E0. The reader enters STREAM at E1. `pix_valid` goes high after E2 with pixel 0.
- A burst is exactly NPIX consecutive cycles with `pix_valid` high. It is never interrupted.
- Inter-burst spacing when the next buffer is already full: `pix_valid` is low for exactly FRAME_GAP+1 cycles between `frame_last` and the next `frame_start`.
- `frame_start` and `frame_last` are each high for exactly one cycle per frame. They are never high together, since NPIX > 1.

## Test plan
- Reset: hold `rst_n` low for 5 cycles with random `wr_valid`. Required: all outputs 0, `buf_full = 00`, and `wr_ready = 1` after release.
- Single frame: write bytes `i%256` for i = 0..783 back-to-back. Required:
  - `pix_valid` rises 2 edges after the last accept.
  - 784 contiguous pixels equal to `i%256`.
  - `frame_start` on pixel 0 and `frame_last` on pixel 783.
  - `buf_full` returns to 00.
- Back-to-back frames: write frame A (value 0x11) immediately followed by frame B (value 0x22). Required: frame B burst starts exactly FRAME_GAP+1 low cycles after A's `frame_last`, and its data is all 0x22.
- Backpressure: write 3 frames continuously. Required:
  - `wr_ready` drops after frame 2 completes, with `buf_full = 11`.
  - `wr_ready` rises on the cycle after the last read of frame 1 is issued.
  - No pixel is lost or duplicated in frame 3.
- Gapped input: drive `wr_valid` at 30% random density. Required: the output burst is still 784 contiguous cycles with correct data.
- Reset mid-stream: assert `rst_n` low at pixel 300 of a burst. Required: `pix_valid` is low the next cycle and no further output appears. A fresh frame written afterwards replays correctly into buffer 0.

Source files
------------

// File: rtl/cnn_pixel_streamer.sv
// Double-buffered frame loader in front of cnn_top. Bytes from the source fill
// one buffer while the other is replayed as a single 784-cycle burst, followed
// by a fixed idle gap so the CNN pipeline can drain.
module cnn_pixel_streamer #(
   parameter int PIX_W     = 8,
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int FRAME_GAP = 500
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [PIX_W-1:0] wr_data_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   output logic [PIX_W-1:0] pix_out_o,
   output logic             pix_valid_o,
   output logic             frame_start_o,
   output logic             frame_last_o,
   output logic [1:0]       buf_full_o
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   // gap counter only has to reach FRAME_GAP-1
   localparam int GW   = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(FRAME_GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_e;

   state_e             state_q, state_d;
   logic               wr_sel_q, wr_sel_d;
   logic               rd_sel_q, rd_sel_d;
   logic [AW-1:0]      wr_addr_q, wr_addr_d;
   logic [AW-1:0]      rd_addr_q, rd_addr_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   logic [1:0]         buf_full_q, buf_full_d;
   logic [PIX_W-1:0]   pix_out_q;
   logic               pix_valid_q, frame_start_q, frame_last_q;

   logic               wr_ready, wr_fire, wr_done;
   logic               rd_issue, rd_done;
   logic [1:0][PIX_W-1:0] rd_word;

   // Only the buffer being filled accepts bytes; a full buffer blocks the source.
   assign wr_ready = !buf_full_q[wr_sel_q];
   assign wr_fire  = wr_valid_i && wr_ready;
   assign wr_done  = wr_fire && (wr_addr_q == LAST_ADDR);

   for (genvar b = 0; b < 2; b++) begin : g_buf
      logic [PIX_W-1:0] mem [NPIX];
      // write port: byte lands only in the buffer currently selected for fill
      always_ff @(posedge clk_i) begin
         if (wr_fire && (wr_sel_q == 1'(b))) mem[wr_addr_q] <= wr_data_i;
      end
      assign rd_word[b] = mem[rd_addr_q];
   end

   // Reader FSM next state: wait for a full buffer, stream it, then idle for the gap.
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      gap_cnt_d = gap_cnt_q;
      rd_issue  = 1'b0;
      rd_done   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (buf_full_q[rd_sel_q]) begin
               state_d   = S_STREAM;
               rd_addr_d = '0;
            end
         end
         S_STREAM: begin
            rd_issue = 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
               rd_done   = 1'b1;
               state_d   = S_GAP;
               rd_addr_d = '0;
               gap_cnt_d = '0;
            end else begin
               rd_addr_d = rd_addr_q + AW'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = S_IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Writer pointers and full flags; release and completion may land on the same edge.
   always_comb begin
      wr_sel_d   = wr_sel_q;
      wr_addr_d  = wr_addr_q;
      rd_sel_d   = rd_sel_q;
      buf_full_d = buf_full_q;
      if (wr_fire) wr_addr_d = wr_done ? '0 : wr_addr_q + AW'(1);
      if (rd_done) begin
         buf_full_d[rd_sel_q] = 1'b0;
         rd_sel_d             = !rd_sel_q;
      end
      if (wr_done) begin
         buf_full_d[wr_sel_q] = 1'b1;
         wr_sel_d             = !wr_sel_q;
      end
   end

   // State registers plus output stage that carries the read issued last cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q       <= S_IDLE;
         wr_sel_q      <= 1'b0;
         rd_sel_q      <= 1'b0;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         gap_cnt_q     <= '0;
         buf_full_q    <= 2'b00;
         pix_out_q     <= '0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_last_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_sel_q      <= wr_sel_d;
         rd_sel_q      <= rd_sel_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         gap_cnt_q     <= gap_cnt_d;
         buf_full_q    <= buf_full_d;
         pix_valid_q   <= rd_issue;
         frame_start_q <= rd_issue && (rd_addr_q == '0);
         frame_last_q  <= rd_done;
         if (rd_issue) pix_out_q <= rd_word[rd_sel_q];
      end
   end

   assign wr_ready_o    = wr_ready;
   assign pix_out_o     = pix_out_q;
   assign pix_valid_o   = pix_valid_q;
   assign frame_start_o = frame_start_q;
   assign frame_last_o  = frame_last_q;
   assign buf_full_o    = buf_full_q;

endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Bench for cnn_pixel_streamer: frame-level timing model plus directed scenarios.
module tb_cnn_pixel_streamer;

   localparam int PIX_W     = 8;
   localparam int IMG_W     = 28;
   localparam int IMG_H     = 28;
   localparam int FRAME_GAP = 500;
   localparam int NPIX      = IMG_W * IMG_H;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wr_valid = 1'b0;
   logic [PIX_W-1:0] wr_data = '0;
   logic             wr_ready;
   logic [PIX_W-1:0] pix_out;
   logic             pix_valid, frame_start, frame_last;
   logic [1:0]       buf_full;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   cnn_pixel_streamer #(
      .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .FRAME_GAP(FRAME_GAP)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
      .wr_ready_o(wr_ready), .pix_out_o(pix_out), .pix_valid_o(pix_valid),
      .frame_start_o(frame_start), .frame_last_o(frame_last), .buf_full_o(buf_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: output stream is the accepted byte stream in order; burst
   // k starts max(completion_k+2, end_{k-1}+FRAME_GAP+2) edges; a buffer frees
   // on the edge its last pixel appears.
   initial begin : model
      logic [7:0] q_pix[$];
      int         comp_q[$];
      int         cnt_in, bs, next_free, thr, i;
      bit         active, armed, set_f, clr_f, r, v;
      bit         ws, rs;
      bit [1:0]   bf;
      logic [7:0] d, e_pix;
      bit         e_valid, e_start, e_last, chk_pix;
      armed = 0; active = 0; cnt_in = 0; bs = 0; next_free = 0;
      ws = 0; rs = 0; bf = 2'b00;
      e_valid = 0; e_start = 0; e_last = 0; chk_pix = 0; e_pix = '0;
      forever begin
         @(posedge clk);
         cyc++;
         r = rst_n; v = wr_valid; d = wr_data;
         if (!r) begin
            armed = 1; active = 0; cnt_in = 0; next_free = 0;
            ws = 0; rs = 0; bf = 2'b00;
            q_pix.delete(); comp_q.delete();
            e_valid = 0; e_start = 0; e_last = 0; e_pix = '0; chk_pix = 1;
         end else begin
            set_f = 0; clr_f = 0;
            if (v && !bf[ws]) begin
               q_pix.push_back(d);
               cnt_in++;
               if (cnt_in == NPIX) begin
                  cnt_in = 0;
                  comp_q.push_back(cyc);
                  set_f = 1;
               end
            end
            e_valid = 0; e_start = 0; e_last = 0; chk_pix = 0;
            if (!active && comp_q.size() > 0) begin
               thr = comp_q[0] + 2;
               if (next_free > thr) thr = next_free;
               if (cyc >= thr) begin
                  active = 1; bs = cyc;
                  void'(comp_q.pop_front());
               end
            end
            if (active) begin
               i = cyc - bs;
               e_valid = 1; chk_pix = 1;
               if (q_pix.size() == 0) begin
                  chk("model_underflow", 0, 1);
                  e_pix = '0;
               end else e_pix = q_pix.pop_front();
               e_start = (i == 0);
               e_last  = (i == NPIX - 1);
               if (e_last) begin
                  active = 0; clr_f = 1;
                  next_free = cyc + FRAME_GAP + 2;
               end
            end
            if (clr_f) begin bf[rs] = 1'b0; rs = !rs; end
            if (set_f) begin bf[ws] = 1'b1; ws = !ws; end
         end
         @(negedge clk);
         if (armed) begin
            chk("wr_ready", int'(wr_ready), int'(!bf[ws]));
            chk("buf_full", int'(buf_full), int'(bf));
            chk("pix_valid", int'(pix_valid), int'(e_valid));
            chk("frame_start", int'(frame_start), int'(e_start));
            chk("frame_last", int'(frame_last), int'(e_last));
            if (chk_pix) chk("pix_out", int'(pix_out), int'(e_pix));
         end
      end
   end

   task automatic align();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Present one byte, optionally after random idle cycles, and hold it until taken.
   task automatic push_pix(input logic [7:0] d, input int pct, output int acc_cyc);
      bit rdy;
      int guard;
      while ($urandom_range(99) >= pct) begin
         wr_valid = 1'b0; wr_data = 8'($urandom);
         @(posedge clk); #1;
      end
      wr_valid = 1'b1; wr_data = d; guard = 0;
      forever begin
         @(negedge clk); rdy = wr_ready;
         @(posedge clk); #1;
         if (rdy) break;
         guard++;
         if (guard > 5000) begin
            chk("push_timeout", 0, 1);
            break;
         end
      end
      acc_cyc = cyc;
      wr_valid = 1'b0;
   endtask

   // kind 0: constant base, kind 1: (i+base)%256, kind 2: random bytes
   function automatic logic [7:0] pat(input int kind, input int base, input int i);
      if (kind == 0) return 8'(base);
      return 8'((i + base) % 256);
   endfunction

   task automatic send_frame(input int kind, input int base, input int pct,
                             output int first_acc, output int last_acc);
      int a;
      logic [7:0] d;
      first_acc = 0; last_acc = 0;
      for (int i = 0; i < NPIX; i++) begin
         d = (kind == 2) ? 8'($urandom) : pat(kind, base, i);
         push_pix(d, pct, a);
         if (i == 0) first_acc = a;
         last_acc = a;
      end
   endtask

   task automatic watch_burst(input int kind, input int base,
                              output int s_cyc, output int e_cyc, output int len);
      int guard, bad;
      guard = 0; len = 0; bad = 0; s_cyc = 0; e_cyc = 0;
      @(negedge clk);
      while (!pix_valid && guard < 20000) begin
         @(negedge clk); guard++;
      end
      if (!pix_valid) begin
         chk("burst_timeout", 0, 1);
         return;
      end
      s_cyc = cyc;
      while (pix_valid && len < NPIX + 8) begin
         if (frame_start !== (len == 0)) bad++;
         if (frame_last !== (len == NPIX - 1)) bad++;
         if (kind != 2 && pix_out !== pat(kind, base, len)) bad++;
         len++;
         e_cyc = cyc;
         @(negedge clk);
      end
      chk("burst_len", len, NPIX);
      chk("burst_bad", bad, 0);
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int f, l, s, e, n, sa, ea, sb, eb, f1, l1, f2, l2, f3, l3, s1, e1, nv;

      // reset with random traffic on the write side
      for (int k = 0; k < 5; k++) begin
         wr_valid = 1'($urandom); wr_data = 8'($urandom);
         @(posedge clk); #1;
      end
      rst_n = 1'b1; wr_valid = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(wr_ready), 1);
      chk("rst_full", int'(buf_full), 0);
      chk("rst_valid", int'(pix_valid), 0);
      align();

      // single frame of i%256
      fork
         send_frame(1, 0, 100, f, l);
         watch_burst(1, 0, s, e, n);
      join
      chk("single_latency", s - l, 2);
      idle(FRAME_GAP + 5);
      @(negedge clk);
      chk("single_full_clear", int'(buf_full), 0);
      align();

      // back-to-back frames, constant values
      fork
         begin
            send_frame(0, 8'h11, 100, f, l);
            send_frame(0, 8'h22, 100, f, l);
         end
         begin
            watch_burst(0, 8'h11, sa, ea, n);
            watch_burst(0, 8'h22, sb, eb, n);
         end
      join
      chk("b2b_gap", sb - ea - 1, FRAME_GAP + 1);
      idle(FRAME_GAP + 5);

      // backpressure with three frames
      fork
         begin
            send_frame(1, 3, 100, f1, l1);
            send_frame(1, 7, 100, f2, l2);
            @(negedge clk);
            chk("bp_full", int'(buf_full), 3);
            chk("bp_ready", int'(wr_ready), 0);
            align();
            send_frame(1, 11, 100, f3, l3);
         end
         begin
            watch_burst(1, 3, s1, e1, n);
            watch_burst(1, 7, s, e, n);
            watch_burst(1, 11, s, e, n);
         end
      join
      chk("bp_resume", f3 - e1, 1);
      idle(FRAME_GAP + 5);

      // sparse input, random data
      fork
         send_frame(2, 0, 30, f, l);
         watch_burst(2, 0, s, e, n);
      join
      chk("gapped_latency", s - l, 2);
      idle(FRAME_GAP + 5);

      // reset in the middle of a burst
      fork
         send_frame(2, 0, 100, f, l);
         begin
            n = 0;
            @(negedge clk);
            while (!pix_valid && n < 5000) begin @(negedge clk); n++; end
            n = 0;
            while (pix_valid && n < 300) begin @(negedge clk); n++; end
            chk("mid_reached", n, 300);
            rst_n = 1'b0;
            @(negedge clk);
            chk("mid_valid_low", int'(pix_valid), 0);
            @(negedge clk);
            rst_n = 1'b1;
            nv = 0;
            repeat (1000) begin @(negedge clk); if (pix_valid) nv++; end
            chk("mid_quiet", nv, 0);
         end
      join
      align();
      send_frame(1, 5, 100, f, l);
      @(negedge clk);
      chk("refill_buf0", int'(buf_full), 1);
      watch_burst(1, 5, s, e, n);
      chk("refill_latency", s - l, 2);
      idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
